// File: rtl/zclock_pkg.sv
// Shared types and helpers for the Z80 clock generator: phase encoding,
// default geometry and the mode -> half-period mapping.
package zclock_pkg;

  typedef logic [0:0] phase_t;
  localparam phase_t PH_LOW  = 1'b0;
  localparam phase_t PH_HIGH = 1'b1;

  localparam int HALF_BASE_DEF = 4;
  localparam int NUM_TURBO_DEF = 3;

  function automatic int unsigned eff_mode(input int unsigned mode,
                                           input int unsigned num_turbo);
    return (mode < num_turbo) ? mode : num_turbo - 32'd1;
  endfunction

  // Faster modes halve the phase; never let it collapse below one fclk.
  function automatic int unsigned half_period(input int unsigned mode,
                                              input int unsigned base      = HALF_BASE_DEF,
                                              input int unsigned num_turbo = NUM_TURBO_DEF);
    int unsigned h;
    h = base >> eff_mode(mode, num_turbo);
    return (h == 0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/zclock_turbo_latch.sv
// Speed-mode register: samples rfsh_n on each zpos and adopts the requested
// mode only on a falling RFSH edge seen across two consecutive zpos samples.
module zclock_turbo_latch #(
  parameter int TURBO_W = 2
) (
  input  logic               fclk,
  input  logic               rst,
  input  logic               en,
  input  logic               rfsh_n,
  input  logic [TURBO_W-1:0] turbo,
  output logic [TURBO_W-1:0] int_turbo
);

  logic               old_rfsh_n_q, old_rfsh_n_d;
  logic [TURBO_W-1:0] int_turbo_q, int_turbo_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    old_rfsh_n_d = old_rfsh_n_q;
    int_turbo_d  = int_turbo_q;
    if (en) begin
      old_rfsh_n_d = rfsh_n;
      if (old_rfsh_n_q && !rfsh_n) int_turbo_d = turbo;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge fclk) begin
    if (rst) begin
      old_rfsh_n_q <= 1'b1;
      int_turbo_q  <= '0;
    end else begin
      old_rfsh_n_q <= old_rfsh_n_d;
      int_turbo_q  <= int_turbo_d;
    end
  end

  assign int_turbo = int_turbo_q;

endmodule

// File: rtl/zclock_gen.sv
// Parametrised Z80 clock generator with turbo modes, RFSH-gated mode switch
// and wait-stall. Optional DRAM alignment to cbeg: define ZCLOCK_CBEG_SYNC_EN.
module zclock_gen
  import zclock_pkg::*;
#(
  parameter int HALF_BASE = HALF_BASE_DEF,
  parameter int NUM_TURBO = NUM_TURBO_DEF,
  parameter int TURBO_W   = 2,
  parameter int CNT_W     = 4
) (
  input  logic               fclk,
  input  logic               rst,
  input  logic [TURBO_W-1:0] turbo,
  input  logic               rfsh_n,
  input  logic               zclk_stall,
  input  logic               cbeg,
  output logic               zclk_out,
  output logic               zpos,
  output logic               zneg,
  output logic [TURBO_W-1:0] int_turbo,
  output logic               stalled
);

  phase_t             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zpos_q, zpos_d;
  logic               zneg_q, zneg_d;
  logic               stalled_q, stalled_d;
  logic [CNT_W-1:0]   h_m1;
  logic               terminal;

  zclock_turbo_latch #(.TURBO_W(TURBO_W)) u_turbo_latch (
    .fclk      (fclk),
    .rst       (rst),
    .en        (zpos_q),
    .rfsh_n    (rfsh_n),
    .turbo     (turbo),
    .int_turbo (int_turbo)
  );

  // >= rather than == so a shorter H adopted mid-phase ends the phase at once.
  assign h_m1     = CNT_W'(half_period(32'(int_turbo), HALF_BASE, NUM_TURBO) - 32'd1);
  assign terminal = (cnt_q >= h_m1);

`ifndef ZCLOCK_CBEG_SYNC_EN
  logic unused_cbeg;
  assign unused_cbeg = cbeg;
`endif

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    zpos_d    = 1'b0;
    zneg_d    = 1'b0;
    stalled_d = 1'b0;
    if (terminal) begin
      if (zclk_stall) begin
        stalled_d = 1'b1;
      end else begin
        phase_d = (phase_q == PH_HIGH) ? PH_LOW : PH_HIGH;
        cnt_d   = '0;
        zpos_d  = (phase_q == PH_HIGH);
        zneg_d  = (phase_q == PH_LOW);
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
`ifdef ZCLOCK_CBEG_SYNC_EN
      // Pull the falling zclk_out edge onto the cycle after the DRAM anchor.
      if (cbeg && phase_q == PH_HIGH && !zclk_stall &&
          eff_mode(32'(int_turbo), NUM_TURBO) < int unsigned'(NUM_TURBO - 1))
        cnt_d = h_m1;
`endif
    end
  end

  // NOTE: only control state exists here (no memories), so every flop gets an explicit reset value.
  always_ff @(posedge fclk) begin
    if (rst) begin
      phase_q   <= PH_HIGH;
      cnt_q     <= '0;
      zpos_q    <= 1'b0;
      zneg_q    <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      zpos_q    <= zpos_d;
      zneg_q    <= zneg_d;
      stalled_q <= stalled_d;
    end
  end

  assign zclk_out = phase_q;
  assign zpos     = zpos_q;
  assign zneg     = zneg_q;
  assign stalled  = stalled_q;

endmodule

// File: tb/tb_zclock_gen.sv
// Self-checking bench for zclock_gen: directed scenarios plus random stimulus,
// every cycle compared against a phase-age reference model.
module tb_zclock_gen;

  localparam int HB = 4;
  localparam int NT = 3;

  logic       fclk = 1'b0;
  logic       rst, rfsh_n, zclk_stall, cbeg;
  logic [1:0] turbo;
  logic       zclk_out, zpos, zneg, stalled;
  logic [1:0] int_turbo;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current level, how many cycles it has been shown, strobes, mode.
  int m_level = 1, m_age = 1, m_zpos = 0, m_zneg = 0, m_stalled = 0;
  int m_turbo = 0, m_old_rfsh = 1;

  zclock_gen dut (
    .fclk       (fclk),
    .rst        (rst),
    .turbo      (turbo),
    .rfsh_n     (rfsh_n),
    .zclk_stall (zclk_stall),
    .cbeg       (cbeg),
    .zclk_out   (zclk_out),
    .zpos       (zpos),
    .zneg       (zneg),
    .int_turbo  (int_turbo),
    .stalled    (stalled)
  );

  always #5 fclk = ~fclk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_eff(input int mode);
    return (mode < NT) ? mode : NT - 1;
  endfunction

  function automatic int ref_half(input int mode);
    int h;
    h = HB >> ref_eff(mode);
    return (h < 1) ? 1 : h;
  endfunction

  // One fclk edge of the model using the inputs held across that edge.
  task automatic model_edge();
    int h;
    if (rst) begin
      m_level = 1; m_age = 1; m_zpos = 0; m_zneg = 0; m_stalled = 0;
      m_turbo = 0; m_old_rfsh = 1;
    end else begin
      h = ref_half(m_turbo);
      if (m_zpos != 0) begin
        if (m_old_rfsh != 0 && !rfsh_n) m_turbo = int'(turbo);
        m_old_rfsh = int'(rfsh_n);
      end
      m_zpos = 0; m_zneg = 0; m_stalled = 0;
      if (m_age >= h) begin
        if (zclk_stall) begin
          m_stalled = 1;
        end else begin
          if (m_level != 0) m_zpos = 1; else m_zneg = 1;
          m_level = 1 - m_level;
          m_age   = 1;
        end
      end else begin
        m_age = m_age + 1;
`ifdef ZCLOCK_CBEG_SYNC_EN
        if (cbeg && m_level != 0 && !zclk_stall && ref_eff(m_turbo) < NT - 1) m_age = h;
`endif
      end
    end
  endtask

  task automatic step();
    @(posedge fclk);
    #1;
    model_edge();
    check("zclk_out",  int'(zclk_out),  m_level);
    check("zpos",      int'(zpos),      m_zpos);
    check("zneg",      int'(zneg),      m_zneg);
    check("stalled",   int'(stalled),   m_stalled);
    check("int_turbo", int'(int_turbo), m_turbo);
    check("strobe_excl", int'(zpos & zneg), 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cycles_to_zpos(output int n);
    n = 0;
    do begin step(); n++; end while (!zpos && n < 40);
  endtask

  task automatic cycles_to_zneg(output int n);
    n = 0;
    do begin step(); n++; end while (!zneg && n < 40);
  endtask

  task automatic set_mode(input int m);
    turbo  = 2'(m);
    rfsh_n = 1'b1; run(10);
    rfsh_n = 1'b0; run(10);
    rfsh_n = 1'b1;
    check("mode_latch", int'(int_turbo), m);
  endtask

  initial begin
    int n;
    rst = 1'b1; turbo = 2'd0; rfsh_n = 1'b1; zclk_stall = 1'b0; cbeg = 1'b0;
    run(3);
    check("reset_zclk_out", int'(zclk_out), 1);
    check("reset_turbo", int'(int_turbo), 0);

    rst = 1'b0;
    cycles_to_zpos(n);
    check("first_zpos_lat", n, 4);
    cycles_to_zneg(n);
    check("mode0_low_len", n, 4);
    cycles_to_zpos(n);
    check("mode0_high_len", n, 4);
    run(16);

    turbo = 2'd1; rfsh_n = 1'b1; run(20);
    check("turbo_ignored", int'(int_turbo), 0);
    rfsh_n = 1'b0; run(10); rfsh_n = 1'b1;
    check("turbo1_latched", int'(int_turbo), 1);
    run(2);
    cycles_to_zpos(n);
    cycles_to_zpos(n);
    check("mode1_period", n, 4);

    set_mode(2);
    cycles_to_zpos(n);
    cycles_to_zpos(n);
    check("mode2_period", n, 2);
    run(8);

    set_mode(0);
    cycles_to_zneg(n);
    run(3);
    zclk_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_held", int'(stalled), 1);
    end
    zclk_stall = 1'b0;
    cycles_to_zpos(n);
    check("stall_release", n, 1);

    set_mode(3);
    cycles_to_zpos(n);
    cycles_to_zpos(n);
    check("mode3_clamped", n, 2);

    set_mode(1);
    cycles_to_zneg(n);
    step();
    rst = 1'b1; step();
    check("midrst_zclk", int'(zclk_out), 1);
    check("midrst_turbo", int'(int_turbo), 0);
    rst = 1'b0;
    cycles_to_zpos(n);
    check("midrst_first_zpos", n, 4);

`ifdef ZCLOCK_CBEG_SYNC_EN
    cycles_to_zneg(n);
    cbeg = 1'b1; step();
    cbeg = 1'b0; step();
    check("cbeg_align", int'(zpos), 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      turbo      = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rfsh_n = ~rfsh_n;
      zclk_stall = ($urandom_range(0, 3) == 0);
      cbeg       = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/zclock_gen.md
Name: zclock_gen

Overview:
Parametrised Z80 clock generator, successor to the fixed 3.5/7 MHz Z80 clocker. From the fclk master clock it produces:
- zclk_out, the Z80 clock, which is inverted externally.
- One-cycle zpos/zneg edge strobes for the rest of the fclk domain.
It supports NUM_TURBO speed modes (3.5/7/14 MHz at defaults), glitch-free mode switching during RFSH, and wait-stall of clock edges. It sits between the arbiter/DRAM timing logic and the Z80 clock pin.

Parameters:
HALF_BASE, 4, fclk cycles per Z80 half-period in mode 0 (28 MHz / 8 = 3.5 MHz)
NUM_TURBO, 3, number of speed modes; mode m half-period = max(1, HALF_BASE >> m)
TURBO_W, 2, width of turbo select
CNT_W, 4, half-period counter width; must hold HALF_BASE-1

Ports:
fclk  in  1  master clock (28 MHz)
rst  in  1  synchronous reset, active-high
turbo  in  TURBO_W  requested mode, 0 = slowest
rfsh_n  in  1  Z80 RFSH; mode change is allowed only at its falling edge
zclk_stall  in  1  inhibit next Z80 clock edge (wait-stating)
cbeg  in  1  DRAM cycle-begin anchor (used only with the optional feature)
zclk_out  out  1  Z80 clock before external inversion
zpos  out  1  one-cycle strobe: zclk_out fell (Z80 clock rising)
zneg  out  1  one-cycle strobe: zclk_out rose (Z80 clock falling)
int_turbo  out  TURBO_W  mode currently in effect
stalled  out  1  terminal count reached and edge held by zclk_stall

Behaviour:
- Single clock domain: everything is updated on posedge fclk, with one clock and a synchronous active-high reset.
- Reset values: zclk_out=1, zpos=0, zneg=0, int_turbo=0, stalled=0, counter=0, old_rfsh_n=1.
- Effective mode: eff = min(int_turbo, NUM_TURBO-1).
- Half-period: H = HALF_BASE >> eff, clamped to a minimum of 1.
- Phase FSM has two states, LOW (zclk_out=0) and HIGH (zclk_out=1):
  - Terminal condition is cnt >= H-1. The >= compare makes a shrinking H safe mid-phase.
  - Terminal and !zclk_stall: at the same edge, toggle zclk_out, clear cnt, and pulse the strobe for that one cycle. HIGH->LOW pulses zpos; LOW->HIGH pulses zneg. Strobes are coincident with the new zclk_out level.
  - Terminal and zclk_stall: hold zclk_out and cnt, and assert stalled. The toggle occurs on the first cycle with zclk_stall low.
  - Not terminal: cnt increments. zclk_stall has no effect.
- zpos and zneg are never high together. Each is at most 1 cycle wide.
- Mode switch, evaluated only in zpos cycles:
  - old_rfsh_n <= rfsh_n.
  - If old_rfsh_n && !rfsh_n, then int_turbo <= turbo.
  - The new H applies from the next cycle, to the phase already in progress, via the >= rule.
- A turbo change outside that window is ignored until the next qualifying zpos.
- Out-of-range turbo (>= NUM_TURBO) is latched as-is and clamped via eff.
- Reset mid-operation returns all state to the reset values on the next edge. The first zpos comes H(0) cycles after reset deasserts.

Optional Feature:
ZCLOCK_CBEG_SYNC_EN
- Defined: when cbeg=1 in state HIGH, with !zclk_stall and eff<NUM_TURBO-1, cnt is forced to H-1. The zpos edge therefore lands on the next cycle, aligning Z80 edges to DRAM cycles.
- Undefined: cbeg is ignored and edges are free-running from reset.

Decomposition:
- Package zclock_pkg holds:
  - Phase-state typedef (LOW/HIGH).
  - Default HALF_BASE/NUM_TURBO constants.
  - Function half_period(mode).
- One natural sub-module, zclock_turbo_latch: holds the RFSH edge detector and int_turbo register, enabled by zpos.

Test Plan:
1. Reset, turbo=0, no stall -> zpos every 8 cycles; zneg 4 cycles after each zpos; zclk_out low 4 / high 4.
2. turbo=1, rfsh_n held high -> mode stays 0. Then drive rfsh_n low across a zpos -> int_turbo=1; period becomes 4 (2/2) from the following phase.
3. Switch to turbo=2 -> period 2; zpos and zneg alternate every cycle; never both high.
4. Mode 0, zclk_stall high for 5 cycles across a terminal count -> stalled=1; zclk_out held; that phase lengthens by 5 cycles; no strobes while stalled.
5. turbo=3 latched with NUM_TURBO=3 -> int_turbo=3, behaves as mode 2 (period 2).
6. rst pulsed mid-HIGH-phase in mode 1 -> next cycle zclk_out=1, int_turbo=0; first zpos 4 cycles after rst falls. With ZCLOCK_CBEG_SYNC_EN, cbeg in HIGH -> zpos on the following cycle.
